// File: rtl/arp_sequencer_pkg.sv
// arp_pkg: shared constants for the arpeggio note sequencer.
// Holds the pattern encodings, the controller state type, the divisor ROM
// (50 MHz / note frequency, truncated) and the LFSR step used by the random
// pattern when ARP_SEQUENCER_RANDOM_EN is defined.
package arp_pkg;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_UPDOWN = 2'b10;
  localparam logic [1:0] MODE_RANDOM = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    ARP    = 2'd2
  } arp_state_t;

  // C4 D4 E4 F4 G4 A4 B4 C5
  localparam logic [17:0] NOTE_DIV_ROM [8] = '{
    18'd190839, 18'd170068, 18'd151515, 18'd143266,
    18'd127551, 18'd113636, 18'd101214, 18'd95602
  };

  // One step of an 8-bit Galois LFSR, taps 0xB8, shifting right.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    logic [7:0] shifted;
    shifted = v >> 1;
    if (v[0]) begin
      lfsr_next = shifted ^ 8'hB8;
    end else begin
      lfsr_next = shifted;
    end
  endfunction

endpackage

// File: rtl/arp_sequencer_if.sv
// Switch / note bus between the panel (master) and the sequencer (slave).
interface arp_sequencer_if #(parameter int DIV_W = 18);
  logic [7:0]       SW;
  logic             ARP_ON;
  logic [1:0]       MODE;
  logic [DIV_W-1:0] NOTE_DIV;
  logic             NOTE_VALID;
  logic [2:0]       NOTE_IDX;
  logic             STEP_PULSE;
  logic [2:0]       LED;

  modport master (
    output SW, ARP_ON, MODE,
    input  NOTE_DIV, NOTE_VALID, NOTE_IDX, STEP_PULSE, LED
  );

  modport slave (
    input  SW, ARP_ON, MODE,
    output NOTE_DIV, NOTE_VALID, NOTE_IDX, STEP_PULSE, LED
  );
endinterface

// File: rtl/arp_sequencer_note_scan.sv
// note_scan: circular search of an 8-bit note mask.
// Checks start, then start+1, start+2 ... (or start-1 ... when down is set),
// wrapping modulo 8, and returns the first set position. An empty mask
// returns start; the caller never acts on that case.
module note_scan (
  input  logic [7:0] mask,
  input  logic [2:0] start,
  input  logic       down,
  output logic [2:0] idx
);

  logic [2:0] pos;

  // Walk the scan order backwards so the earliest hit is written last
  always_comb begin
    idx = start;
    pos = start;
    for (int k = 7; k >= 0; k--) begin
      if (down) begin
        pos = start - 3'(k);
      end else begin
        pos = start + 3'(k);
      end
      if (mask[pos]) begin
        idx = pos;
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/arp_sequencer.sv
// arp_sequencer: note controller in front of the tone generator.
// Direct mode sounds the lowest held switch; arpeggio mode steps through the
// held notes every STEP_CYCLES with a GAP_CYCLES gate-off at the end of each
// step, in up / down / up-down / random order.
// Optional feature macro: ARP_SEQUENCER_RANDOM_EN (LFSR-driven random
// pattern for MODE=11; without it MODE=11 plays the up pattern).
module arp_sequencer
  import arp_pkg::*;
#(
  parameter int STEP_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 500000,
  parameter int DIV_W       = 18
) (
  input  logic            CLK50MHZ,
  input  logic            RST_N,
  arp_sequencer_if.slave  bus
);

  localparam int TW = $clog2(STEP_CYCLES);
  localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] GAP_START = TW'(STEP_CYCLES - GAP_CYCLES);

  logic [7:0]       sw_meta, sw_sync;
  logic             arp_meta, arp_sync;
  arp_state_t       state;
  logic [TW-1:0]    timer;
  logic             dir_down;
  logic [DIV_W-1:0] note_div;
  logic             note_valid;
  logic [2:0]       note_idx;
  logic             step_pulse;

  logic [2:0]       scan_start, scan_idx;
  logic             scan_down, dir_next;
  logic [7:0]       higher_mask, lower_mask;

`ifdef ARP_SEQUENCER_RANDOM_EN
  logic [7:0]       lfsr;

  // Free-running pseudo-random source for the random pattern
  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end
`endif

  // Two-flop synchronizers for the asynchronous switch inputs
  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      sw_meta  <= 8'd0;
      sw_sync  <= 8'd0;
      arp_meta <= 1'b0;
      arp_sync <= 1'b0;
    end else begin
      sw_meta  <= bus.SW;
      sw_sync  <= sw_meta;
      arp_meta <= bus.ARP_ON;
      arp_sync <= arp_meta;
    end
  end

  // Held notes strictly above / below the sounding one (up-down turnaround)
  assign higher_mask = sw_sync & ~((8'd2 << note_idx) - 8'd1);
  assign lower_mask  = sw_sync &  ((8'd1 << note_idx) - 8'd1);

  // Choose where the note search starts and which way it runs
  always_comb begin
    scan_start = 3'd0;
    scan_down  = 1'b0;
    dir_next   = dir_down;
    if (!arp_sync || state != ARP) begin
      // Direct note or first arpeggio step: lowest held note, highest for down
      scan_down  = arp_sync && (bus.MODE == MODE_DOWN);
      scan_start = scan_down ? 3'd7 : 3'd0;
      dir_next   = 1'b0;
    end else begin
      case (bus.MODE)
        MODE_DOWN: begin
          scan_start = note_idx - 3'd1;
          scan_down  = 1'b1;
        end
        MODE_UPDOWN: begin
          if (!dir_down) begin
            if (higher_mask != 8'd0) begin
              scan_start = note_idx + 3'd1;
              scan_down  = 1'b0;
              dir_next   = 1'b0;
            end else begin
              scan_start = note_idx - 3'd1;
              scan_down  = 1'b1;
              dir_next   = 1'b1;
            end
          end else begin
            if (lower_mask != 8'd0) begin
              scan_start = note_idx - 3'd1;
              scan_down  = 1'b1;
              dir_next   = 1'b1;
            end else begin
              scan_start = note_idx + 3'd1;
              scan_down  = 1'b0;
              dir_next   = 1'b0;
            end
          end
        end
`ifdef ARP_SEQUENCER_RANDOM_EN
        MODE_RANDOM: begin
          scan_start = lfsr[2:0];
          scan_down  = 1'b0;
        end
        MODE_UP: begin
          scan_start = note_idx + 3'd1;
          scan_down  = 1'b0;
        end
`else
        MODE_UP, MODE_RANDOM: begin
          scan_start = note_idx + 3'd1;
          scan_down  = 1'b0;
        end
`endif
        default: begin
          scan_start = note_idx + 3'd1;
          scan_down  = 1'b0;
        end
      endcase
    end
  end

  note_scan u_scan (
    .mask  (sw_sync),
    .start (scan_start),
    .down  (scan_down),
    .idx   (scan_idx)
  );

  // Controller FSM: state, step timer, direction and all registered outputs
  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      timer      <= '0;
      dir_down   <= 1'b0;
      note_div   <= '0;
      note_valid <= 1'b0;
      note_idx   <= 3'd0;
      step_pulse <= 1'b0;
    end else begin
      if (sw_sync == 8'd0) begin
        state      <= IDLE;
        timer      <= '0;
        note_div   <= '0;
        note_valid <= 1'b0;
        step_pulse <= 1'b0;
      end else if (!arp_sync) begin
        state      <= DIRECT;
        timer      <= '0;
        dir_down   <= 1'b0;
        note_idx   <= scan_idx;
        note_div   <= DIV_W'(NOTE_DIV_ROM[scan_idx]);
        note_valid <= 1'b1;
        step_pulse <= 1'b0;
      end else if (state != ARP || !sw_sync[note_idx] || timer == STEP_LAST) begin
        // New step: entry, sounding note released, or step boundary
        state      <= ARP;
        timer      <= '0;
        dir_down   <= dir_next;
        note_idx   <= scan_idx;
        note_div   <= DIV_W'(NOTE_DIV_ROM[scan_idx]);
        note_valid <= 1'b1;
        step_pulse <= 1'b1;
      end else begin
        timer      <= timer + TW'(1);
        note_valid <= (timer + TW'(1)) < GAP_START;
        step_pulse <= 1'b0;
      end
    end
  end

  assign bus.NOTE_DIV   = note_div;
  assign bus.NOTE_VALID = note_valid;
  assign bus.NOTE_IDX   = note_idx;
  assign bus.STEP_PULSE = step_pulse;
  assign bus.LED        = note_idx;

endmodule

// File: tb/tb_arp_sequencer.sv
// Directed bench for arp_sequencer with a short step (16 cycles, 4-cycle gap).
// Expected note indices are queued as stimulus is applied and popped at each
// STEP_PULSE; step length and gate gap are measured between pulses.
`timescale 1ns/1ps
module tb_arp_sequencer;

  localparam int STEP = 16;
  localparam int GAP  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  arp_sequencer_if #(.DIV_W(18)) bus();

  arp_sequencer #(.STEP_CYCLES(STEP), .GAP_CYCLES(GAP), .DIV_W(18)) dut (
    .CLK50MHZ (clk),
    .RST_N    (rst_n),
    .bus      (bus)
  );

  int n_assert;
  int n_fail;
  int pulses;
  int exp_q[$];
  logic [17:0] rom_ref [8] = '{18'd190839, 18'd170068, 18'd151515, 18'd143266,
                               18'd127551, 18'd113636, 18'd101214, 18'd95602};
  logic [7:0] lfsr_m, lfsr_prev;

  // Reference LFSR, previous value is what the DUT used at the last edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_m    <= 8'hA5;
      lfsr_prev <= 8'hA5;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= lfsr_m[0] ? ((lfsr_m >> 1) ^ 8'hB8) : (lfsr_m >> 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Wait for n step pulses; compare each against the queue head
  task automatic run_steps(input int n, input bit chain, input bit rnd);
    int waited, low, e;
    for (int k = 0; k < n; k++) begin
      waited = 0;
      low = 0;
      do begin
        tick();
        waited++;
        if (!bus.STEP_PULSE && !bus.NOTE_VALID) low++;
      end while (!bus.STEP_PULSE && waited < 40);
      chk("pulse_seen", 32'(bus.STEP_PULSE), 32'd1);
      if (rnd && k > 0) exp_q.push_back(int'(lfsr_prev[2:0]));
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk("arp_idx", 32'(bus.NOTE_IDX), e);
      chk("arp_div", 32'(bus.NOTE_DIV), 32'(rom_ref[e[2:0]]));
      chk("arp_valid", 32'(bus.NOTE_VALID), 32'd1);
      chk("arp_led", 32'(bus.LED), e);
      if (k > 0 || chain) begin
        chk("step_len", waited, STEP);
        chk("gap_len", low, GAP);
      end
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    bus.SW = 8'h00;
    bus.ARP_ON = 1'b0;
    bus.MODE = 2'b00;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_div", 32'(bus.NOTE_DIV), 32'd0);
    chk("rst_valid", 32'(bus.NOTE_VALID), 32'd0);
    chk("rst_idx", 32'(bus.NOTE_IDX), 32'd0);
    chk("rst_pulse", 32'(bus.STEP_PULSE), 32'd0);
    chk("rst_led", 32'(bus.LED), 32'd0);
    rst_n = 1'b1;
    tick();

    // Direct mode, single note 5
    bus.SW = 8'h20;
    pulses = 0;
    tick(); if (bus.STEP_PULSE) pulses++;
    tick(); if (bus.STEP_PULSE) pulses++;
    chk("direct_latency", 32'(bus.NOTE_VALID), 32'd0);
    tick(); if (bus.STEP_PULSE) pulses++;
    chk("direct_div", 32'(bus.NOTE_DIV), 32'd113636);
    chk("direct_idx", 32'(bus.NOTE_IDX), 32'd5);
    chk("direct_valid", 32'(bus.NOTE_VALID), 32'd1);
    chk("direct_led", 32'(bus.LED), 32'd5);
    repeat (20) begin tick(); if (bus.STEP_PULSE) pulses++; end
    chk("direct_no_pulse", pulses, 0);

    // Arpeggio up over notes 0,2,4
    bus.SW = 8'h15;
    bus.MODE = 2'b00;
    bus.ARP_ON = 1'b1;
    exp_q = '{0, 2, 4, 0, 2, 4};
    run_steps(6, 1'b0, 1'b0);

    // ARP_ON falling returns to direct without a pulse
    bus.ARP_ON = 1'b0;
    pulses = 0;
    repeat (3) begin tick(); if (bus.STEP_PULSE) pulses++; end
    chk("arp_off_pulse", pulses, 0);
    chk("arp_off_idx", 32'(bus.NOTE_IDX), 32'd0);
    chk("arp_off_div", 32'(bus.NOTE_DIV), 32'd190839);
    chk("arp_off_valid", 32'(bus.NOTE_VALID), 32'd1);

    // Up-down
    bus.MODE = 2'b10;
    bus.ARP_ON = 1'b1;
    exp_q = '{0, 2, 4, 2, 0, 2};
    run_steps(6, 1'b0, 1'b0);
    bus.ARP_ON = 1'b0;
    repeat (4) tick();

    // Down
    bus.MODE = 2'b01;
    bus.ARP_ON = 1'b1;
    exp_q = '{4, 2, 0, 4};
    run_steps(4, 1'b0, 1'b0);
    bus.ARP_ON = 1'b0;
    repeat (4) tick();

    // Release the sounding note mid-step
    bus.MODE = 2'b00;
    bus.ARP_ON = 1'b1;
    exp_q = '{0, 2};
    run_steps(2, 1'b0, 1'b0);
    repeat (3) tick();
    bus.SW = 8'h11;
    tick();
    tick();
    chk("release_early_pulse", 32'(bus.STEP_PULSE), 32'd0);
    tick();
    chk("release_pulse", 32'(bus.STEP_PULSE), 32'd1);
    chk("release_idx", 32'(bus.NOTE_IDX), 32'd4);
    chk("release_valid", 32'(bus.NOTE_VALID), 32'd1);
    exp_q = '{0};
    run_steps(1, 1'b1, 1'b0);

    // Single held note repeats with gap every step
    bus.SW = 8'h80;
    exp_q = '{7, 7, 7};
    run_steps(3, 1'b0, 1'b0);

    // All released: idle
    bus.SW = 8'h00;
    repeat (3) tick();
    chk("idle_valid", 32'(bus.NOTE_VALID), 32'd0);
    chk("idle_div", 32'(bus.NOTE_DIV), 32'd0);
    chk("idle_pulse", 32'(bus.STEP_PULSE), 32'd0);

    // Random pattern
    bus.MODE = 2'b11;
    bus.SW = 8'hFF;
`ifdef ARP_SEQUENCER_RANDOM_EN
    exp_q = '{0};
    run_steps(9, 1'b0, 1'b1);
`else
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    run_steps(9, 1'b0, 1'b0);
`endif

    // Asynchronous reset mid-step
    repeat (5) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_div", 32'(bus.NOTE_DIV), 32'd0);
    chk("async_rst_valid", 32'(bus.NOTE_VALID), 32'd0);
    chk("async_rst_idx", 32'(bus.NOTE_IDX), 32'd0);
    chk("async_rst_pulse", 32'(bus.STEP_PULSE), 32'd0);
    chk("async_rst_led", 32'(bus.LED), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
